// File: rtl/lcd_text_driver_pkg.sv
// Shared types and command bytes for the HD44780 16x2 text driver.
// Optional LCD_FRAME_DONE_EN adds a frame_done pulse on the top.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    ADDR,
    FETCH,
    WRITE
  } state_e;

  typedef enum logic [1:0] {
    K_INIT,
    K_ADDR,
    K_DATA
  } kind_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } phase_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam int CHARS_PER_LINE = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    c = LCD_CLEAR;
    unique case (1'b1)
      (i == 2'd0): c = LCD_FUNC_SET;
      (i == 2'd1): c = LCD_DISP_ON;
      (i == 2'd2): c = LCD_ENTRY;
      (i == 2'd3): c = LCD_CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// Character fetch bus toward the mode blocks plus the LCD pins.
// master = driver side, slave = display/mode-block side.
interface lcd_text_driver_if;
  logic [4:0] index;
  logic [7:0] char_in;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (
    output index,
    output lcd_e,
    output lcd_rs,
    output lcd_rw,
    output lcd_data,
    input  char_in
  );

  modport slave (
    input  index,
    input  lcd_e,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_data,
    output char_in
  );
endinterface

// File: rtl/lcd_text_driver_write_strobe.sv
// One LCD write: setup cycle, E pulse, then post-write wait.
// Clear (0x01 with rs=0) uses the long wait.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] wr_byte,
  input  logic       wr_rs,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int CNT_MAX =
    max2(E_PULSE_CYC, max2(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = long_q ? CNT_W'(CLR_WAIT_CYC - 1)
                            : CNT_W'(CMD_WAIT_CYC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
    end
  end

  // byte and rs are captured at start and held through the whole wait
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    unique case (phase_q)
      PH_IDLE: begin
        if (start) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
          data_d  = wr_byte;
          rs_d    = wr_rs;
          long_d  = !wr_rs && (wr_byte == LCD_CLEAR);
        end
      end
      PH_SETUP: begin
        phase_d = PH_PULSE;
        cnt_d   = '0;
      end
      PH_PULSE: begin
        if (cnt_q == CNT_W'(E_PULSE_CYC - 1)) begin
          phase_d = PH_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_WAIT: begin
        if (cnt_q == wait_last) begin
          phase_d = PH_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_comb begin
    lcd_e    = (phase_q == PH_PULSE);
    done     = (phase_q == PH_WAIT) && (cnt_q == wait_last);
    lcd_rs   = rs_q;
    lcd_data = data_q;
  end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 refresh driver: power-up init, then endless refresh.
// Define LCD_FRAME_DONE_EN to add the frame_done output pulse.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int PWRUP_WAIT_CYC = 1000000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 100000
) (
  input  logic                clk,
  input  logic                rst,
  lcd_text_driver_if.master   bus,
  output logic                ready
`ifdef LCD_FRAME_DONE_EN
  ,
  output logic                frame_done
`endif
);

  localparam int PW_W = $clog2(PWRUP_WAIT_CYC) + 1;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [PW_W-1:0] pw_q, pw_d;
  logic [1:0]      init_q, init_d;
  logic            line_q, line_d;
  logic [4:0]      index_q, index_d;
  logic            fetch_q, fetch_d;
  logic            ready_q, ready_d;
  logic            fd_q, fd_d;

  logic            start;
  logic [7:0]      wr_byte;
  logic            wr_rs;
  logic            wr_done;

  lcd_write_strobe #(
    .E_PULSE_CYC  (E_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wr_byte  (wr_byte),
    .wr_rs    (wr_rs),
    .done     (wr_done),
    .lcd_e    (bus.lcd_e),
    .lcd_rs   (bus.lcd_rs),
    .lcd_data (bus.lcd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PWRUP;
      kind_q  <= K_INIT;
      pw_q    <= '0;
      init_q  <= '0;
      line_q  <= 1'b0;
      index_q <= '0;
      fetch_q <= 1'b0;
      ready_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pw_q    <= pw_d;
      init_q  <= init_d;
      line_q  <= line_d;
      index_q <= index_d;
      fetch_q <= fetch_d;
      ready_q <= ready_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pw_d    = pw_q;
    init_d  = init_q;
    line_d  = line_q;
    index_d = index_q;
    fetch_d = fetch_q;
    ready_d = ready_q;
    fd_d    = 1'b0;
    unique case (state_q)
      PWRUP: begin
        if (pw_q == PW_W'(PWRUP_WAIT_CYC - 1)) begin
          state_d = INIT;
          pw_d    = '0;
        end else begin
          pw_d = pw_q + 1'b1;
        end
      end
      INIT: begin
        kind_d  = K_INIT;
        state_d = WRITE;
      end
      ADDR: begin
        kind_d  = K_ADDR;
        index_d = line_q ? 5'(CHARS_PER_LINE) : 5'd0;
        state_d = WRITE;
      end
      // char_in is registered upstream: valid on the 2nd edge
      FETCH: begin
        if (fetch_q) begin
          fetch_d = 1'b0;
          kind_d  = K_DATA;
          state_d = WRITE;
        end else begin
          fetch_d = 1'b1;
        end
      end
      WRITE: begin
        if (wr_done) begin
          unique case (kind_q)
            K_INIT: begin
              if (init_q == 2'd3) begin
                ready_d = 1'b1;
                line_d  = 1'b0;
                init_d  = '0;
                state_d = ADDR;
              end else begin
                init_d  = init_q + 1'b1;
                state_d = INIT;
              end
            end
            K_ADDR: begin
              fetch_d = 1'b0;
              state_d = FETCH;
            end
            K_DATA: begin
              if (index_q[3:0] != 4'(CHARS_PER_LINE - 1)) begin
                index_d = index_q + 1'b1;
                fetch_d = 1'b0;
                state_d = FETCH;
              end else if (index_q[4]) begin
                index_d = '0;
                line_d  = 1'b0;
                fd_d    = 1'b1;
                state_d = ADDR;
              end else begin
                line_d  = 1'b1;
                state_d = ADDR;
              end
            end
            default: state_d = PWRUP;
          endcase
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    wr_byte = bus.char_in;
    wr_rs   = 1'b0;
    unique case (state_q)
      INIT: begin
        start   = 1'b1;
        wr_byte = init_cmd(init_q);
      end
      ADDR: begin
        start   = 1'b1;
        wr_byte = line_q ? LCD_LINE2 : LCD_LINE1;
      end
      FETCH: begin
        start = fetch_q;
        wr_rs = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.index  = index_q;
  assign bus.lcd_rw = 1'b0;
  assign ready      = ready_q;

`ifdef LCD_FRAME_DONE_EN
  assign frame_done = fd_q;
`else
  logic unused_fd;
  assign unused_fd = fd_q;
`endif

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with short timing parameters.
// Covers init, two refresh frames, sample timing, mid-run reset.
module tb_lcd_text_driver;

  localparam int PW  = 16;
  localparam int EP  = 2;
  localparam int CW  = 4;
  localparam int CLW = 8;

  logic clk;
  logic rst;
  logic ready;
`ifdef LCD_FRAME_DONE_EN
  logic frame_done;
`endif

  lcd_text_driver_if bus();

  lcd_text_driver #(
    .PWRUP_WAIT_CYC (PW),
    .E_PULSE_CYC    (EP),
    .CMD_WAIT_CYC   (CW),
    .CLR_WAIT_CYC   (CLW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ready      (ready)
`ifdef LCD_FRAME_DONE_EN
    ,
    .frame_done (frame_done)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];

  // mode block model: registered lookup, one cycle latency
  always @(posedge clk) bus.char_in <= mem[bus.index];

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         hi;
    int         gap;
  } rec_t;

  rec_t       recs[$];
  int         low;
  int         hi;
  int         gap_rise;
  logic       prev_e;
  logic       prev_rdy;
  logic [7:0] cur_d;
  logic       cur_rs;
  int         viol;
  int         rdy_lag;
  int         rdy_n;
  int         checks;
  int         fails;
`ifdef LCD_FRAME_DONE_EN
  int         fd_pos[$];
  int         fd_w;
  int         fd_wmax;
  logic       prev_fd;
`endif

  always @(negedge clk) begin
    if (rst) begin
      prev_e   = 1'b0;
      prev_rdy = 1'b0;
      low      = 0;
      hi       = 0;
`ifdef LCD_FRAME_DONE_EN
      prev_fd  = 1'b0;
      fd_w     = 0;
`endif
    end else begin
      if (bus.lcd_rw !== 1'b0) viol++;
      if (bus.lcd_e && !prev_e) begin
        gap_rise = low;
        cur_d    = bus.lcd_data;
        cur_rs   = bus.lcd_rs;
        hi       = 1;
      end else if (bus.lcd_e) begin
        hi++;
        if (bus.lcd_data !== cur_d || bus.lcd_rs !== cur_rs) viol++;
      end else if (prev_e) begin
        recs.push_back('{data: cur_d, rs: cur_rs, hi: hi, gap: gap_rise});
        low = 1;
      end else begin
        low++;
      end
      if (!bus.lcd_e && recs.size() > 0 && low <= CW &&
          (bus.lcd_data !== cur_d || bus.lcd_rs !== cur_rs)) viol++;
      if (ready && !prev_rdy) begin
        rdy_lag = low;
        rdy_n   = recs.size();
      end
`ifdef LCD_FRAME_DONE_EN
      if (frame_done) begin
        fd_w++;
        if (fd_w > fd_wmax) fd_wmax = fd_w;
        if (!prev_fd) fd_pos.push_back(recs.size());
      end else begin
        fd_w = 0;
      end
      prev_fd = frame_done;
`endif
      prev_e   = bus.lcd_e;
      prev_rdy = ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_init(input string pfx);
    logic [7:0] exp_cmd [4];
    exp_cmd = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_cmd%0d_data", pfx, i), 32'(recs[i].data),
          32'(exp_cmd[i]));
      chk($sformatf("%s_cmd%0d_rs", pfx, i), 32'(recs[i].rs), 0);
      chk($sformatf("%s_cmd%0d_ehi", pfx, i), recs[i].hi, EP);
      chk($sformatf("%s_cmd%0d_gap", pfx, i), recs[i].gap,
          (i == 0) ? PW + 1 : CW + 2);
    end
    chk({pfx, "_rdy_lag"}, rdy_lag, CLW + 1);
    chk({pfx, "_rdy_after"}, rdy_n, 4);
    chk({pfx, "_line1_data"}, 32'(recs[4].data), 32'h80);
    chk({pfx, "_line1_gap"}, recs[4].gap, CLW + 2);
  endtask

  initial begin
    int waited;
    int base;
    int r;
    logic [7:0] exp;
    clk     = 1'b0;
    rst     = 1'b1;
    viol    = 0;
    checks  = 0;
    fails   = 0;
    rdy_lag = -1;
    rdy_n   = -1;
    bus.char_in = 8'h00;
`ifdef LCD_FRAME_DONE_EN
    fd_wmax = 0;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h41 + i);

    repeat (3) @(negedge clk);
    chk("rst_index", 32'(bus.index), 0);
    chk("rst_e", 32'(bus.lcd_e), 0);
    chk("rst_rs", 32'(bus.lcd_rs), 0);
    chk("rst_rw", 32'(bus.lcd_rw), 0);
    chk("rst_data", 32'(bus.lcd_data), 0);
    chk("rst_ready", 32'(ready), 0);
`ifdef LCD_FRAME_DONE_EN
    chk("rst_frame_done", 32'(frame_done), 0);
`endif
    recs.delete();
    #2 rst = 1'b0;

    // swap mem[5] right after its sample edge in frame 0
    waited = 0;
    while (bus.index !== 5'd5 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("idx5_reached", 32'(waited < 2000), 1);
    @(posedge clk);
    @(posedge clk);
    #1 mem[5] = 8'h7A;

    waited = 0;
    while (recs.size() < 73 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("two_frames_timeout", 32'(waited < 5000), 1);

    if (recs.size() >= 73) begin
      chk_init("pwr");
      for (int f = 0; f < 2; f++) begin
        base = 4 + 34 * f;
        chk($sformatf("f%0d_l1_data", f), 32'(recs[base].data), 32'h80);
        chk($sformatf("f%0d_l1_rs", f), 32'(recs[base].rs), 0);
        chk($sformatf("f%0d_l2_data", f), 32'(recs[base + 17].data),
            32'hC0);
        chk($sformatf("f%0d_l2_rs", f), 32'(recs[base + 17].rs), 0);
        chk($sformatf("f%0d_l2_gap", f), recs[base + 17].gap, CW + 2);
        for (int i = 0; i < 32; i++) begin
          r   = (i < 16) ? base + 1 + i : base + 2 + i;
          exp = (f == 1 && i == 5) ? 8'h7A : 8'(8'h41 + i);
          chk($sformatf("f%0d_c%0d_data", f, i), 32'(recs[r].data),
              32'(exp));
          chk($sformatf("f%0d_c%0d_rs", f, i), 32'(recs[r].rs), 1);
          chk($sformatf("f%0d_c%0d_ehi", f, i), recs[r].hi, EP);
          chk($sformatf("f%0d_c%0d_gap", f, i), recs[r].gap, CW + 3);
        end
      end
      chk("f2_l1_data", 32'(recs[72].data), 32'h80);
      chk("f2_l1_gap", recs[72].gap, CW + 2);
    end
    chk("bus_stability", viol, 0);
`ifdef LCD_FRAME_DONE_EN
    chk("fd_count", fd_pos.size(), 2);
    if (fd_pos.size() >= 2) begin
      chk("fd0_pos", fd_pos[0], 38);
      chk("fd1_pos", fd_pos[1], 72);
    end
    chk("fd_width", fd_wmax, 1);
`endif

    // reset while E is high on the index-20 character
    waited = 0;
    while (!(bus.index === 5'd20 && bus.lcd_e === 1'b1) &&
           waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("idx20_e_reached", 32'(waited < 2000), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_e", 32'(bus.lcd_e), 0);
    chk("mid_rst_index", 32'(bus.index), 0);
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_data", 32'(bus.lcd_data), 0);
    chk("mid_rst_rs", 32'(bus.lcd_rs), 0);
    @(negedge clk);
    recs.delete();
    rdy_lag = -1;
    rdy_n   = -1;
`ifdef LCD_FRAME_DONE_EN
    fd_pos.delete();
`endif
    @(negedge clk);
    #2 rst = 1'b0;

    waited = 0;
    while (recs.size() < 5 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("reinit_timeout", 32'(waited < 1000), 1);
    if (recs.size() >= 5) chk_init("re");
`ifdef LCD_FRAME_DONE_EN
    chk("re_fd_none", fd_pos.size(), 0);
`endif
    chk("bus_stability_end", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
